uart_frame_sampler: RTL and testbench
=====================================

# uart_frame_sampler

Parametrised UART receive sampler that replaces the single-bit majority sampler. Armed by a start pulse from the start-bit detector, it tracks oversampling phase on its own and produces one majority-voted estimate per bit period for a complete frame. It also flags non-unanimous (noisy) votes and reports the index of each bit. It sits between the start-bit detector and the UART deframer, and it uses the same `sample_trigger` strobe as the rest of the RX path.

## Interface
- `OVERSAMPLE`, 16: triggers per bit period; legal range 4..64.
- `WINDOW`, 5: vote window in samples; must be odd, 1..OVERSAMPLE-1.
- `NUM_BITS`, 10: bits per frame, counting start, data and stop bits; legal range 1..32.
- `clk` input 1: system clock, much faster than the bitrate.
- `rst_n` input 1: asynchronous active-low reset.
- `sample_trigger` input 1: one-clk strobe at OVERSAMPLE × bitrate.
- `start` input 1: one-clk pulse that arms or re-arms frame capture.
- `raw_data` input 1: synchronised RX line.
- `estimated_data` output 1: voted bit value.
- `estimate_ready` output 1: one-clk pulse when `estimated_data`, `estimate_noisy` and `bit_index` are valid.
- `estimate_noisy` output 1: the vote window was not unanimous.
- `bit_index` output $clog2(NUM_BITS) (min 1): index of the emitted bit, 0-based.
- `busy` output 1: high while in COLLECT.
- `frame_done` output 1: one-clk pulse coincident with the last `estimate_ready`.

## Operation
- Two states, IDLE and COLLECT.
  - Reset puts the block in IDLE.
  - `start` moves the block to COLLECT from either state. On that edge it clears the phase counter, the bit counter and the window shift register.
- In IDLE, `sample_trigger` is ignored.
- In COLLECT, each `sample_trigger`:
  - shifts `raw_data` into a WINDOW-bit shift register;
  - advances `phase`, a $clog2(OVERSAMPLE)-bit counter, modulo OVERSAMPLE. It wraps explicitly at OVERSAMPLE-1, so it does not rely on power-of-2 rollover.
- The first trigger after `start` is phase 0.
- EST_PHASE = OVERSAMPLE/2 + (WINDOW-1)/2, so the window is centred on phase OVERSAMPLE/2.
  - Defaults: EST_PHASE = 10, and the vote uses the samples from phases 6..10.
- Estimate step, on the trigger where `phase == EST_PHASE`:
  - The vote covers the WINDOW most recent samples, including the current `raw_data`.
  - `estimated_data` = 1 if the count of ones is ≥ (WINDOW+1)/2.
  - `estimate_noisy` = 1 if the count of ones is neither 0 nor WINDOW.
  - `bit_index` = the bit counter.
  - `estimate_ready` pulses.
  - The bit counter then increments.
- When the estimate is for bit NUM_BITS-1:
  - `frame_done` pulses together with `estimate_ready`;
  - the state returns to IDLE.
- Popcount width is $clog2(WINDOW+1). All comparisons are unsigned.
- `estimated_data`, `estimate_noisy` and `bit_index` hold their values until the next estimate.

## Timing
- Every output resets to 0 asynchronously when `rst_n` is low, and stays 0 while `rst_n` is held low.
- All outputs are registered. `estimate_ready` rises on the clk edge that samples the EST_PHASE trigger, and is high for exactly one clk.
- Latency:
  - first estimate: the cycle after the (EST_PHASE+1)th trigger following `start`;
  - each later estimate: exactly OVERSAMPLE triggers after the previous one.
- `busy` rises the cycle after `start` and falls in the same cycle as `frame_done` is asserted.
- `start` and `sample_trigger` in the same cycle: `start` wins and that trigger is not counted.
- `start` mid-frame aborts the current frame. No `frame_done` is produced, and `bit_index` restarts at 0.
- Deasserting `rst_n` mid-frame gives IDLE immediately with all outputs 0. The next `start` is required before any further estimate.
- Back-to-back `sample_trigger` on every clk is legal.

## Configuration
- `UART_FRAME_SAMPLER_NOISE_EN`, when defined: the popcount is compared against 0 and WINDOW, and `estimate_noisy` behaves as described in Operation.
- When not defined: `estimate_noisy` is tied to 0 and the unanimity compare logic is removed. `estimated_data` and `estimate_ready` are unaffected.

## Test plan
All tests use the defaults (16/5/10), `sample_trigger` every 4 clks, and `UART_FRAME_SAMPLER_NOISE_EN` defined.

- **Clean all-ones frame.** `start`, then `raw_data` = 1 for 160 triggers.
  - Expect ten `estimate_ready` pulses, each with data 1 and noisy 0, and `bit_index` 0..9.
  - The first pulse comes one clk after trigger 11.
  - `frame_done` comes with the 10th pulse, `busy` falls, and later triggers produce nothing.
- **Glitch rejected.** Bit 0 is all ones except zeros at phases 7 and 8.
  - Expect data 1, noisy 1.
  - Bit 1 is clean: expect noisy 0.
- **Majority zero.** Zeros at phases 6, 8 and 10 of bit 2, ones elsewhere.
  - Expect `bit_index` 2, data 0, noisy 1.
- **Restart.** Second `start` after bit 4, issued in the same cycle as a trigger.
  - Expect that trigger to be ignored.
  - The next estimate has `bit_index` 0 and arrives one clk after trigger 11 counted from the second `start`.
  - Exactly 10 more pulses follow, then one `frame_done`.
- **Async reset mid-frame.** Assert `rst_n` low, between clk edges, during bit 6.
  - Expect all outputs 0 immediately.
  - After release, triggers without `start` produce no `estimate_ready`.
- **Macro undefined.** Rerun the glitch test.
  - Expect data 1 and `estimate_noisy` held at 0 throughout.

Source files
------------

// File: rtl/uart_frame_sampler.sv
// Frame-level UART RX sampler: per-bit majority vote over a window centred mid-bit.
// Optional unanimity (noise) flag enabled by defining UART_FRAME_SAMPLER_NOISE_EN.
module uart_frame_sampler #(
   parameter  int OVERSAMPLE = 16,
   parameter  int WINDOW     = 5,
   parameter  int NUM_BITS   = 10,
   localparam int BI_W       = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            sample_trigger,
   input  logic            start,
   input  logic            raw_data,
   output logic            estimated_data,
   output logic            estimate_ready,
   output logic            estimate_noisy,
   output logic [BI_W-1:0] bit_index,
   output logic            busy,
   output logic            frame_done
);

   localparam int PH_W      = $clog2(OVERSAMPLE);
   localparam int PC_W      = $clog2(WINDOW + 1);
   localparam int EST_PHASE = OVERSAMPLE / 2 + (WINDOW - 1) / 2;
   localparam int MAJORITY  = (WINDOW + 1) / 2;

   typedef enum logic {
      S_IDLE,
      S_COLLECT
   } state_e;

   state_e            state_q, state_d;
   logic [PH_W-1:0]   phase_q, phase_d;
   logic [BI_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [WINDOW-1:0] win_q, win_d;
   logic              data_q, data_d;
   logic              noisy_q, noisy_d;
   logic [BI_W-1:0]   idx_q, idx_d;
   logic              ready_q, ready_d;
   logic              done_q, done_d;

   logic [WINDOW-1:0] win_shift;
   logic [PC_W-1:0]   ones;
   logic              noisy_vote;

   function automatic logic [PC_W-1:0] popcount(input logic [WINDOW-1:0] v);
      logic [PC_W-1:0] n;
      n = '0;
      for (int i = 0; i < WINDOW; i++) begin
         n = n + PC_W'(v[i]);
      end
      return n;
   endfunction

   // The vote includes the sample arriving on this very trigger.
   assign win_shift = WINDOW'({win_q, raw_data});
   assign ones      = popcount(win_shift);

`ifdef UART_FRAME_SAMPLER_NOISE_EN
   assign noisy_vote = (ones != '0) && (ones != PC_W'(WINDOW));
`else
   assign noisy_vote = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q;
      bit_cnt_d = bit_cnt_q;
      win_d     = win_q;
      data_d    = data_q;
      noisy_d   = noisy_q;
      idx_d     = idx_q;
      ready_d   = 1'b0;
      done_d    = 1'b0;
      // start has priority: a coincident trigger is dropped, not counted.
      if (start) begin
         state_d   = S_COLLECT;
         phase_d   = '0;
         bit_cnt_d = '0;
         win_d     = '0;
      end else if ((state_q == S_COLLECT) && sample_trigger) begin
         win_d   = win_shift;
         phase_d = (phase_q == PH_W'(OVERSAMPLE - 1)) ? '0 : phase_q + PH_W'(1);
         if (phase_q == PH_W'(EST_PHASE)) begin
            data_d    = (ones >= PC_W'(MAJORITY));
            noisy_d   = noisy_vote;
            idx_d     = bit_cnt_q;
            ready_d   = 1'b1;
            bit_cnt_d = bit_cnt_q + BI_W'(1);
            if (bit_cnt_q == BI_W'(NUM_BITS - 1)) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         phase_q   <= '0;
         bit_cnt_q <= '0;
         win_q     <= '0;
         data_q    <= 1'b0;
         noisy_q   <= 1'b0;
         idx_q     <= '0;
         ready_q   <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         bit_cnt_q <= bit_cnt_d;
         win_q     <= win_d;
         data_q    <= data_d;
         noisy_q   <= noisy_d;
         idx_q     <= idx_d;
         ready_q   <= ready_d;
         done_q    <= done_d;
      end
   end

   assign estimated_data = data_q;
   assign estimate_noisy = noisy_q;
   assign bit_index      = idx_q;
   assign estimate_ready = ready_q;
   assign frame_done     = done_q;
   assign busy           = (state_q == S_COLLECT);

endmodule

// File: tb/tb_uart_frame_sampler.sv
// Directed self-checking bench for uart_frame_sampler (defaults 16/5/10, trigger every 4 clks).
module tb_uart_frame_sampler;

`ifdef UART_FRAME_SAMPLER_NOISE_EN
   localparam logic NOISE = 1'b1;
`else
   localparam logic NOISE = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic       sample_trigger;
   logic       start;
   logic       raw_data;
   logic       estimated_data;
   logic       estimate_ready;
   logic       estimate_noisy;
   logic [3:0] bit_index;
   logic       busy;
   logic       frame_done;

   int tests_run = 0;
   int failed    = 0;
   int ready_cnt = 0;
   int done_cnt  = 0;

   logic       r_ready, r_data, r_noisy, r_done, r_busy;
   logic [3:0] r_idx;

   uart_frame_sampler dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .sample_trigger (sample_trigger),
      .start          (start),
      .raw_data       (raw_data),
      .estimated_data (estimated_data),
      .estimate_ready (estimate_ready),
      .estimate_noisy (estimate_noisy),
      .bit_index      (bit_index),
      .busy           (busy),
      .frame_done     (frame_done)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst_n === 1'b1 && estimate_ready === 1'b1) ready_cnt++;
      if (rst_n === 1'b1 && frame_done === 1'b1) done_cnt++;
   end

   // Enter and leave at a negedge; capture outputs half a clk after the sampling edge.
   task automatic trig(input logic v);
      raw_data       = v;
      sample_trigger = 1'b1;
      @(negedge clk);
      sample_trigger = 1'b0;
      r_ready = estimate_ready;
      r_data  = estimated_data;
      r_noisy = estimate_noisy;
      r_idx   = bit_index;
      r_done  = frame_done;
      r_busy  = busy;
      repeat (3) @(negedge clk);
   endtask

   task automatic do_start(input logic with_trig);
      start          = 1'b1;
      sample_trigger = with_trig;
      @(negedge clk);
      start          = 1'b0;
      sample_trigger = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b1; start = 1'b0; sample_trigger = 1'b0; raw_data = 1'b1;
      #3 rst_n = 1'b0;
      #1;
      tests_run++;
      if ({estimated_data, estimate_ready, estimate_noisy, bit_index, busy, frame_done} !== 9'd0) begin
         failed++;
         $display("FAIL reset_outputs: got %b expected all zero",
                  {estimated_data, estimate_ready, estimate_noisy, bit_index, busy, frame_done});
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      trig(1'b1);
      tests_run++;
      if (r_ready !== 1'b0 || r_busy !== 1'b0) begin
         failed++;
         $display("FAIL reset_idle_trigger: got ready=%b busy=%b expected 0 0", r_ready, r_busy);
      end
   endtask

   task automatic test_clean_frame();
      int base;
      base = ready_cnt;
      do_start(1'b0);
      tests_run++;
      if (busy !== 1'b1) begin
         failed++;
         $display("FAIL clean_busy_rise: got %b expected 1", busy);
      end
      for (int t = 0; t < 160; t++) begin
         trig(1'b1);
         if ((t % 16) == 10) begin
            tests_run++;
            if (r_ready !== 1'b1 || r_data !== 1'b1 || r_noisy !== 1'b0 || r_idx !== 4'(t / 16)
                || r_done !== (t / 16 == 9) || r_busy !== (t / 16 != 9)) begin
               failed++;
               $display("FAIL clean_est_%0d: got rdy=%b d=%b n=%b idx=%0d done=%b busy=%b expected 1 1 0 %0d %b %b",
                        t / 16, r_ready, r_data, r_noisy, r_idx, r_done, r_busy, t / 16,
                        (t / 16 == 9), (t / 16 != 9));
            end
         end else begin
            tests_run++;
            if (r_ready !== 1'b0 || r_done !== 1'b0) begin
               failed++;
               $display("FAIL clean_quiet_t%0d: got rdy=%b done=%b expected 0 0", t, r_ready, r_done);
            end
         end
      end
      for (int t = 0; t < 16; t++) trig(1'b1);
      tests_run++;
      if (ready_cnt - base !== 10 || busy !== 1'b0) begin
         failed++;
         $display("FAIL clean_pulse_count: got %0d busy=%b expected 10 busy=0", ready_cnt - base, busy);
      end
   endtask

   task automatic test_glitch();
      do_start(1'b0);
      for (int p = 0; p < 16; p++) trig((p == 7 || p == 8) ? 1'b0 : 1'b1);
      // Captured values hold until the next estimate.
      tests_run++;
      if (estimated_data !== 1'b1 || estimate_noisy !== NOISE || bit_index !== 4'd0) begin
         failed++;
         $display("FAIL glitch_bit0: got d=%b n=%b idx=%0d expected 1 %b 0",
                  estimated_data, estimate_noisy, bit_index, NOISE);
      end
      for (int p = 0; p < 16; p++) trig(1'b1);
      tests_run++;
      if (estimated_data !== 1'b1 || estimate_noisy !== 1'b0 || bit_index !== 4'd1) begin
         failed++;
         $display("FAIL glitch_bit1_clean: got d=%b n=%b idx=%0d expected 1 0 1",
                  estimated_data, estimate_noisy, bit_index);
      end
   endtask

   task automatic test_majority_zero();
      do_start(1'b0);
      for (int p = 0; p < 32; p++) trig(1'b1);
      for (int p = 0; p < 16; p++) begin
         trig((p == 6 || p == 8 || p == 10) ? 1'b0 : 1'b1);
         if (p == 10) begin
            tests_run++;
            if (r_ready !== 1'b1 || r_idx !== 4'd2 || r_data !== 1'b0 || r_noisy !== NOISE) begin
               failed++;
               $display("FAIL majority_zero: got rdy=%b idx=%0d d=%b n=%b expected 1 2 0 %b",
                        r_ready, r_idx, r_data, r_noisy, NOISE);
            end
         end
      end
   endtask

   task automatic test_restart();
      int base_r, base_d;
      do_start(1'b0);
      base_r = ready_cnt;
      base_d = done_cnt;
      for (int t = 0; t < 80; t++) trig(1'b1);
      tests_run++;
      if (ready_cnt - base_r !== 5) begin
         failed++;
         $display("FAIL restart_pre_count: got %0d expected 5", ready_cnt - base_r);
      end
      raw_data = 1'b1;
      do_start(1'b1);
      base_r = ready_cnt;
      for (int k = 1; k <= 160; k++) begin
         trig(1'b1);
         if (k == 10) begin
            tests_run++;
            if (r_ready !== 1'b0) begin
               failed++;
               $display("FAIL restart_early: got rdy=%b at trigger 10 expected 0", r_ready);
            end
         end
         if (k == 11) begin
            tests_run++;
            if (r_ready !== 1'b1 || r_idx !== 4'd0) begin
               failed++;
               $display("FAIL restart_first: got rdy=%b idx=%0d expected 1 0", r_ready, r_idx);
            end
         end
      end
      tests_run++;
      if (ready_cnt - base_r !== 10 || done_cnt - base_d !== 1) begin
         failed++;
         $display("FAIL restart_counts: got ready=%0d done=%0d expected 10 1",
                  ready_cnt - base_r, done_cnt - base_d);
      end
   endtask

   task automatic test_async_reset();
      int base;
      do_start(1'b0);
      for (int t = 0; t < 107; t++) trig(1'b1);
      tests_run++;
      if (bit_index !== 4'd6 || busy !== 1'b1 || estimated_data !== 1'b1) begin
         failed++;
         $display("FAIL areset_pre: got idx=%0d busy=%b d=%b expected 6 1 1",
                  bit_index, busy, estimated_data);
      end
      #2 rst_n = 1'b0;
      #1;
      tests_run++;
      if ({estimated_data, estimate_ready, estimate_noisy, bit_index, busy, frame_done} !== 9'd0) begin
         failed++;
         $display("FAIL areset_outputs: got %b expected all zero",
                  {estimated_data, estimate_ready, estimate_noisy, bit_index, busy, frame_done});
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      base = ready_cnt;
      for (int t = 0; t < 32; t++) trig(1'b1);
      tests_run++;
      if (ready_cnt - base !== 0 || busy !== 1'b0) begin
         failed++;
         $display("FAIL areset_no_start: got ready=%0d busy=%b expected 0 0", ready_cnt - base, busy);
      end
   endtask

   initial begin
      test_reset();
      test_clean_frame();
      test_glitch();
      test_majority_zero();
      test_restart();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, failed);
      $finish;
   end

endmodule
